// File: rtl/muxb2_rr_pkg.sv
// Shared types and sizing for the round-robin feeder in front of the inverting 2:1 mux bank.
package muxb2_rr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL0 = 2'd1,
    SEL1 = 2'd2
  } state_e;

  localparam int QDEPTH = 2;
  localparam int CNT_W  = $clog2(QDEPTH + 1);

  // Round-robin pick: rr breaks a tie, otherwise the lone requester wins.
  function automatic logic winner(input logic v0, input logic v1, input logic rr);
    return (v0 && v1) ? rr : v1;
  endfunction

endpackage

// File: rtl/muxb2_rr_feeder_if.sv
// Source channels, mux-bank drive/return and consumer port of the feeder, grouped as one bundle.
interface muxb2_rr_feeder_if #(parameter int WIDTH = 8);
  logic             IN0_VALID;
  logic             IN0_READY;
  logic [WIDTH-1:0] IN0_DATA;
  logic             IN1_VALID;
  logic             IN1_READY;
  logic [WIDTH-1:0] IN1_DATA;
  logic [WIDTH-1:0] MUX_A0;
  logic [WIDTH-1:0] MUX_A1;
  logic             MUX_SL;
  logic [WIDTH-1:0] MUX_ZN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;

  modport slave (
    input  IN0_VALID, IN0_DATA, IN1_VALID, IN1_DATA, MUX_ZN, OUT_READY,
    output IN0_READY, IN1_READY, MUX_A0, MUX_A1, MUX_SL, OUT_VALID, OUT_DATA
  );

  modport master (
    output IN0_VALID, IN0_DATA, IN1_VALID, IN1_DATA, MUX_ZN, OUT_READY,
    input  IN0_READY, IN1_READY, MUX_A0, MUX_A1, MUX_SL, OUT_VALID, OUT_DATA
  );
endinterface

// File: rtl/muxb2_out_q2.sv
// Two-entry valid/ready FIFO holding restored mux-bank results; exposes its fill count.
module muxb2_out_q2
  import muxb2_rr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [QDEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         do_push, do_pop;

  always_comb begin
    do_push  = push_valid && (cnt_q != CNT_W'(QDEPTH));
    do_pop   = out_ready && (cnt_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    // Simultaneous push and pop leaves the count alone.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = cnt_q;

endmodule

// File: rtl/muxb2_rr_feeder.sv
// Round-robin feeder: steers one of two sources through the external inverting mux bank via a
// registered SL, restores polarity of the bank output and queues it for the consumer.
module muxb2_rr_feeder
  import muxb2_rr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               CK,
  input logic               RN,
  muxb2_rr_feeder_if.slave  bus
);

  state_e           state_q, state_d;
  logic             sl_q, sl_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] q_cnt;
  logic             q_full;
  logic             push;
  logic             rdy0, rdy1;
  logic             win;
  logic             cur_ch, cur_v, oth_v, nxt_ch;

  // Both data buses go straight to the bank; only SL decides which one comes back.
  assign bus.MUX_A0 = bus.IN0_DATA;
  assign bus.MUX_A1 = bus.IN1_DATA;
  assign bus.MUX_SL = sl_q;

  always_comb begin
    state_d = state_q;
    sl_d    = sl_q;
    rr_d    = rr_q;
    push    = 1'b0;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    cur_ch  = 1'b0;
    cur_v   = 1'b0;
    oth_v   = 1'b0;
    nxt_ch  = 1'b0;
    q_full  = (q_cnt == CNT_W'(QDEPTH));
    win     = winner(bus.IN0_VALID, bus.IN1_VALID, rr_q);
    case (state_q)
      // Bubble cycle: SL is loaded here and the bank settles before the first capture.
      IDLE: begin
        if (bus.IN0_VALID || bus.IN1_VALID) begin
          state_d = win ? SEL1 : SEL0;
          sl_d    = win;
        end
      end
      SEL0, SEL1: begin
        cur_ch = (state_q == SEL1);
        cur_v  = cur_ch ? bus.IN1_VALID : bus.IN0_VALID;
        oth_v  = cur_ch ? bus.IN0_VALID : bus.IN1_VALID;
        if (!cur_v) begin
          state_d = IDLE;
        end else if (!q_full) begin
          push   = 1'b1;
          rr_d   = ~cur_ch;
          rdy0   = ~cur_ch;
          rdy1   = cur_ch;
          // Hand over to the other source if it waits, else keep streaming the current one.
          nxt_ch  = oth_v ? ~cur_ch : cur_ch;
          state_d = nxt_ch ? SEL1 : SEL0;
          sl_d    = nxt_ch;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      sl_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sl_q    <= sl_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.IN0_READY = rdy0;
  assign bus.IN1_READY = rdy1;

  muxb2_out_q2 #(.WIDTH(WIDTH)) u_q (
    .clk        (CK),
    .rst_n      (RN),
    .push_valid (push),
    .push_data  (~bus.MUX_ZN),
    .out_valid  (bus.OUT_VALID),
    .out_ready  (bus.OUT_READY),
    .out_data   (bus.OUT_DATA),
    .count      (q_cnt)
  );

endmodule

// File: tb/tb_muxb2_rr_feeder.sv
// Bench for muxb2_rr_feeder: inverting mux bank model, queue-fed sources and an output scoreboard.
module tb_muxb2_rr_feeder;
  import muxb2_rr_pkg::*;

  localparam int W = 8;

  logic CK = 1'b0;
  logic RN = 1'b0;
  always #5 CK = ~CK;

  muxb2_rr_feeder_if #(.WIDTH(W)) bus ();

  muxb2_rr_feeder #(.WIDTH(W)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus.slave)
  );

  // Bank of inverting 2:1 mux cells: Z = ~(SL ? A1 : A0)
  for (genvar i = 0; i < W; i++) begin : g_bank
    assign bus.MUX_ZN[i] = ~(bus.MUX_SL ? bus.MUX_A1[i] : bus.MUX_A0[i]);
  end

  typedef struct {int cyc; bit ch; bit sl;} acc_t;

  int         n_chk = 0;
  int         n_ok  = 0;
  int         cyc   = 0;
  int         wait0 = 0;
  logic [W-1:0] src0[$], src1[$], exp_q[$], out_log[$];
  int         out_cyc[$];
  acc_t       acc_log[$];

  // Drives sources from their queues, logs accepts/outputs and runs the scoreboard.
  task automatic monitor();
    logic a0, a1, pp;
    logic [W-1:0] ex;
    acc_t e;
    forever begin
      @(negedge CK);
      cyc++;
      if (!RN) exp_q.delete();
      a0 = bus.IN0_VALID && bus.IN0_READY;
      a1 = bus.IN1_VALID && bus.IN1_READY;
      pp = bus.OUT_VALID && bus.OUT_READY;
      if (bus.IN0_VALID && !bus.IN0_READY) wait0++;
      if (pp) begin
        out_log.push_back(bus.OUT_DATA);
        out_cyc.push_back(cyc);
        n_chk++;
        if (exp_q.size() == 0) $display("FAIL sb_unexpected: got %0h with nothing expected", bus.OUT_DATA);
        else begin
          ex = exp_q.pop_front();
          if (bus.OUT_DATA !== ex) $display("FAIL sb_data: got %0h exp %0h", bus.OUT_DATA, ex);
          else n_ok++;
        end
      end
      if (a0) begin
        exp_q.push_back(bus.IN0_DATA);
        e.cyc = cyc; e.ch = 1'b0; e.sl = bus.MUX_SL; acc_log.push_back(e);
      end
      if (a1) begin
        exp_q.push_back(bus.IN1_DATA);
        e.cyc = cyc; e.ch = 1'b1; e.sl = bus.MUX_SL; acc_log.push_back(e);
      end
      @(posedge CK); #1;
      if (a0 && src0.size() > 0) void'(src0.pop_front());
      if (a1 && src1.size() > 0) void'(src1.pop_front());
      bus.IN0_VALID = (src0.size() > 0);
      bus.IN0_DATA  = (src0.size() > 0) ? src0[0] : '0;
      bus.IN1_VALID = (src1.size() > 0);
      bus.IN1_DATA  = (src1.size() > 0) ? src1[0] : '0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || exp_q.size() > 0 || bus.OUT_VALID) && n < 1500) begin
      @(posedge CK); #2;
      n++;
    end
    if (n >= 1500) begin
      n_chk++;
      $display("FAIL %s_timeout: got still busy after %0d cycles exp drained", name, n);
    end
    repeat (2) @(posedge CK);
    #2;
  endtask

  task automatic clear_logs();
    acc_log.delete(); out_log.delete(); out_cyc.delete(); wait0 = 0;
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(posedge CK);
    #2;
    n_chk++; if (bus.OUT_VALID !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", bus.OUT_VALID); else n_ok++;
    n_chk++; if (bus.IN0_READY !== 1'b0) $display("FAIL rst_in0_ready: got %b exp 0", bus.IN0_READY); else n_ok++;
    n_chk++; if (bus.IN1_READY !== 1'b0) $display("FAIL rst_in1_ready: got %b exp 0", bus.IN1_READY); else n_ok++;
    n_chk++; if (bus.OUT_DATA !== 8'h00) $display("FAIL rst_out_data: got %0h exp 0", bus.OUT_DATA); else n_ok++;
    n_chk++; if (bus.MUX_SL !== 1'b0) $display("FAIL rst_sl: got %b exp 0", bus.MUX_SL); else n_ok++;
    @(negedge CK);
    RN = 1'b1;
    src1.push_back(8'h5A);
    for (n = 0; n < 20 && acc_log.size() == 0; n++) begin
      @(posedge CK); #2;
    end
    #1;
    n_chk++; if (dut.q_cnt !== 2'd1) $display("FAIL pre_rst_count: got %0d exp 1", dut.q_cnt); else n_ok++;
    n_chk++; if (bus.MUX_SL !== 1'b1) $display("FAIL pre_rst_sl: got %b exp 1", bus.MUX_SL); else n_ok++;
    // Mid-cycle reset: outputs must clear without waiting for a clock edge.
    RN = 1'b0;
    #1;
    n_chk++; if (bus.OUT_VALID !== 1'b0) $display("FAIL async_out_valid: got %b exp 0", bus.OUT_VALID); else n_ok++;
    n_chk++; if (bus.OUT_DATA !== 8'h00) $display("FAIL async_out_data: got %0h exp 0", bus.OUT_DATA); else n_ok++;
    n_chk++; if (bus.MUX_SL !== 1'b0) $display("FAIL async_sl: got %b exp 0", bus.MUX_SL); else n_ok++;
    n_chk++; if (dut.q_cnt !== 2'd0) $display("FAIL async_count: got %0d exp 0", dut.q_cnt); else n_ok++;
    n_chk++; if ({bus.IN0_READY, bus.IN1_READY} !== 2'b00) $display("FAIL async_ready: got %b exp 00", {bus.IN0_READY, bus.IN1_READY}); else n_ok++;
    repeat (2) @(negedge CK);
    RN = 1'b1;
    clear_logs();
    bus.OUT_READY = 1'b1;
    src0.push_back(8'h01);
    src1.push_back(8'h02);
    wait_idle("post_rst");
    n_chk++; if (acc_log.size() !== 2) $display("FAIL post_rst_accepts: got %0d exp 2", acc_log.size()); else n_ok++;
    if (acc_log.size() == 2) begin
      n_chk++; if (acc_log[0].ch !== 1'b0) $display("FAIL post_rst_first_grant: got %0d exp 0", acc_log[0].ch); else n_ok++;
    end
  endtask

  task automatic test_single();
    clear_logs();
    bus.OUT_READY = 1'b1;
    src0.push_back(8'h3C); src0.push_back(8'hA5); src0.push_back(8'hFF);
    wait_idle("single");
    n_chk++; if (wait0 !== 1) $display("FAIL single_bubble: got %0d exp 1", wait0); else n_ok++;
    n_chk++; if (acc_log.size() !== 3) $display("FAIL single_accepts: got %0d exp 3", acc_log.size()); else n_ok++;
    n_chk++; if (out_log.size() !== 3) $display("FAIL single_outputs: got %0d exp 3", out_log.size()); else n_ok++;
    if (acc_log.size() == 3 && out_log.size() == 3) begin
      n_chk++; if (acc_log[2].cyc - acc_log[0].cyc !== 2) $display("FAIL single_acc_span: got %0d exp 2", acc_log[2].cyc - acc_log[0].cyc); else n_ok++;
      n_chk++; if (out_cyc[0] - acc_log[0].cyc !== 1) $display("FAIL single_latency: got %0d exp 1", out_cyc[0] - acc_log[0].cyc); else n_ok++;
      n_chk++; if (out_cyc[2] - out_cyc[0] !== 2) $display("FAIL single_out_span: got %0d exp 2", out_cyc[2] - out_cyc[0]); else n_ok++;
      n_chk++; if ((acc_log[0].sl | acc_log[1].sl | acc_log[2].sl) !== 1'b0) $display("FAIL single_sl: got 1 exp 0"); else n_ok++;
      n_chk++; if ({out_log[0], out_log[1], out_log[2]} !== 24'h3CA5FF) $display("FAIL single_data: got %0h exp 3ca5ff", {out_log[0], out_log[1], out_log[2]}); else n_ok++;
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] exp_c[8];
    exp_c = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bus.OUT_READY = 1'b1;
    // A lone channel-1 transfer hands round-robin priority back to channel 0.
    src1.push_back(8'h99);
    wait_idle("cont_pre");
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(exp_c[2*i]);
      src1.push_back(exp_c[2*i+1]);
    end
    wait_idle("cont");
    n_chk++; if (acc_log.size() !== 8) $display("FAIL cont_accepts: got %0d exp 8", acc_log.size()); else n_ok++;
    n_chk++; if (out_log.size() !== 8) $display("FAIL cont_outputs: got %0d exp 8", out_log.size()); else n_ok++;
    if (acc_log.size() == 8 && out_log.size() == 8) begin
      n_chk++; if (acc_log[7].cyc - acc_log[0].cyc !== 7) $display("FAIL cont_no_bubble: got %0d exp 7", acc_log[7].cyc - acc_log[0].cyc); else n_ok++;
      for (int i = 0; i < 8; i++) begin
        n_chk++; if (acc_log[i].ch !== bit'(i % 2)) $display("FAIL cont_grant%0d: got %0d exp %0d", i, acc_log[i].ch, i % 2); else n_ok++;
        n_chk++; if (acc_log[i].sl !== bit'(i % 2)) $display("FAIL cont_sl%0d: got %0d exp %0d", i, acc_log[i].sl, i % 2); else n_ok++;
        n_chk++; if (out_log[i] !== exp_c[i]) $display("FAIL cont_data%0d: got %0h exp %0h", i, out_log[i], exp_c[i]); else n_ok++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_b[8];
    exp_b = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    clear_logs();
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src0.push_back(exp_b[2*i]);
      src1.push_back(exp_b[2*i+1]);
    end
    repeat (7) @(posedge CK);
    #2;
    n_chk++; if (acc_log.size() !== 2) $display("FAIL bp_accepts: got %0d exp 2", acc_log.size()); else n_ok++;
    n_chk++; if ({bus.IN0_READY, bus.IN1_READY} !== 2'b00) $display("FAIL bp_ready: got %b exp 00", {bus.IN0_READY, bus.IN1_READY}); else n_ok++;
    n_chk++; if (dut.q_cnt !== 2'd2) $display("FAIL bp_count: got %0d exp 2", dut.q_cnt); else n_ok++;
    n_chk++; if (bus.OUT_DATA !== 8'hA0) $display("FAIL bp_head: got %0h exp a0", bus.OUT_DATA); else n_ok++;
    bus.OUT_READY = 1'b1;
    wait_idle("bp");
    n_chk++; if (out_log.size() !== 8) $display("FAIL bp_outputs: got %0d exp 8", out_log.size()); else n_ok++;
    if (out_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        n_chk++; if (out_log[i] !== exp_b[i]) $display("FAIL bp_data%0d: got %0h exp %0h", i, out_log[i], exp_b[i]); else n_ok++;
      end
    end
  endtask

  task automatic test_push_pop();
    int n;
    clear_logs();
    bus.OUT_READY = 1'b0;
    src0.push_back(8'hC1); src0.push_back(8'hC2);
    for (n = 0; n < 20 && acc_log.size() == 0; n++) begin
      @(posedge CK); #2;
    end
    n_chk++; if (dut.q_cnt !== 2'd1) $display("FAIL pp_count_pre: got %0d exp 1", dut.q_cnt); else n_ok++;
    bus.OUT_READY = 1'b1;
    @(negedge CK);
    n_chk++; if ({bus.IN0_READY, bus.OUT_VALID} !== 2'b11) $display("FAIL pp_both: got %b exp 11", {bus.IN0_READY, bus.OUT_VALID}); else n_ok++;
    @(posedge CK); #2;
    n_chk++; if (dut.q_cnt !== 2'd1) $display("FAIL pp_count_hold: got %0d exp 1", dut.q_cnt); else n_ok++;
    n_chk++; if (bus.OUT_DATA !== 8'hC2) $display("FAIL pp_head: got %0h exp c2", bus.OUT_DATA); else n_ok++;
    // Keep popping with the queue empty: nothing may change.
    repeat (4) @(posedge CK);
    #2;
    n_chk++; if (dut.q_cnt !== 2'd0) $display("FAIL pp_empty_count: got %0d exp 0", dut.q_cnt); else n_ok++;
    n_chk++; if (bus.OUT_VALID !== 1'b0) $display("FAIL pp_empty_valid: got %b exp 0", bus.OUT_VALID); else n_ok++;
    n_chk++; if (out_log.size() !== 2) $display("FAIL pp_outputs: got %0d exp 2", out_log.size()); else n_ok++;
    if (out_log.size() == 2) begin
      n_chk++; if ({out_log[0], out_log[1]} !== 16'hC1C2) $display("FAIL pp_order: got %0h exp c1c2", {out_log[0], out_log[1]}); else n_ok++;
    end
  endtask

  task automatic test_polarity();
    clear_logs();
    bus.OUT_READY = 1'b1;
    for (int i = 0; i < 256; i++) begin
      src0.push_back(8'(i));
      src1.push_back(8'(255 - i));
    end
    wait_idle("pol");
    n_chk++; if (out_log.size() !== 512) $display("FAIL pol_outputs: got %0d exp 512", out_log.size()); else n_ok++;
    // Last grant before this test went to channel 0, so channel 1 leads the interleave.
    if (out_log.size() == 512) begin
      for (int k = 0; k < 256; k++) begin
        n_chk++; if (out_log[2*k] !== 8'(255 - k)) $display("FAIL pol_ch1_%0d: got %0h exp %0h", k, out_log[2*k], 8'(255 - k)); else n_ok++;
        n_chk++; if (out_log[2*k+1] !== 8'(k)) $display("FAIL pol_ch0_%0d: got %0h exp %0h", k, out_log[2*k+1], 8'(k)); else n_ok++;
      end
    end
  endtask

  initial begin
    bus.IN0_VALID = 1'b0; bus.IN0_DATA = '0;
    bus.IN1_VALID = 1'b0; bus.IN1_DATA = '0;
    bus.OUT_READY = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_push_pop();
    test_polarity();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
